// File: rtl/div_seq_ctrl.sv
// Even-ratio clock divider controller: clean start/stop, boundary-aligned divisor
// updates via valid/ready, and a rise impulse. Define DIV_SEQ_PERIODS_EN for the period counter.
module div_seq_ctrl #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_div,
  output logic             imp,
  output logic             busy,
  output logic [15:0]      periods
);

  typedef enum logic [1:0] {STOP, RUN, DRAIN} state_t;

  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  generate
    if ((DEF_DIV % 2) != 0 || DEF_DIV < 2) begin : g_bad_def
      $error("div_seq_ctrl: DEF_DIV must be even and >= 2");
    end
  endgenerate

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] div_cur, div_nxt, div_n;
  logic             pend, pend_n;
  logic             active, bnd, xfer, bad, take;
  logic             load_now, load_pend, run_n, clk_n;

  always_comb begin
    active    = (state != STOP);
    bnd       = active && (cnt == div_cur - ONE);
    xfer      = cfg_valid && !pend;
    bad       = cfg_div[0] || (cfg_div < TWO);
    take      = xfer && !bad;
    // Stopped, or offered exactly on the wrap: no need to park it in div_nxt.
    load_now  = take && (!active || bnd);
    load_pend = bnd && pend;

    div_n = div_cur;
    if (load_pend)     div_n = div_nxt;
    else if (load_now) div_n = cfg_div;

    pend_n = pend;
    if (load_pend)                      pend_n = 1'b0;
    else if (take && active && !bnd)    pend_n = 1'b1;

    // DRAIN keeps counting until the wrap; enable high at any point resumes RUN.
    run_n = enable || (active && !bnd);
    if (enable)     state_n = RUN;
    else if (run_n) state_n = DRAIN;
    else            state_n = STOP;

    cnt_n = (active && !bnd) ? cnt + ONE : '0;
    clk_n = run_n && (cnt_n >= (div_n >> 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= STOP;
      cnt       <= '0;
      div_cur   <= DEF;
      div_nxt   <= DEF;
      pend      <= 1'b0;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      clk_div   <= 1'b0;
      imp       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      div_cur   <= div_n;
      if (take && active && !bnd) div_nxt <= cfg_div;
      pend      <= pend_n;
      cfg_ready <= !pend_n;
      cfg_err   <= xfer && bad;
      clk_div   <= clk_n;
      imp       <= clk_n && !clk_div;
      busy      <= run_n;
    end
  end

`ifdef DIV_SEQ_PERIODS_EN
  always_ff @(posedge clk) begin
    if (reset)                       periods <= '0;
    else if (load_now || load_pend)  periods <= '0;
    else if (bnd)                    periods <= periods + 16'd1;
  end
`else
  assign periods = '0;
`endif

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Run-time controller for an even-ratio clock divider with an edge-impulse output.
- Starts and stops the divided clock cleanly on `enable`.
- Accepts new divisors through a valid/ready handshake and applies them only at a period boundary, so `clk_div` never shows a runt pulse.
- Sits between the control/register logic and the consumers of the divided clock enable and the impulse.

Parameters:
- CNT_W, 8: width of the divisor and the internal counter.
- DEF_DIV, 6: divisor loaded at reset. Must be even and ≥2; this is checked at elaboration.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  run request; level-sensitive
- cfg_valid  in  1  new divisor offered
- cfg_div  in  CNT_W  offered divisor
- cfg_ready  out  1  controller can accept a divisor
- cfg_err  out  1  one-cycle pulse: offered divisor rejected
- clk_div  out  1  divided clock, registered
- imp  out  1  one-cycle pulse on each `clk_div` rising edge
- busy  out  1  high in RUN or DRAIN
- periods  out  16  completed-period count (see Optional Feature)

Behaviour:
- Registers:
  - `div_cur`: active divisor.
  - `div_nxt`: pending divisor.
  - `pend` flag.
  - `cnt` [CNT_W].
  - `state` ∈ {STOP, RUN, DRAIN}.
- Reset values:
  - `state` = STOP, `cnt` = 0, `div_cur` = DEF_DIV, `pend` = 0.
  - Outputs: `clk_div` = 0, `imp` = 0, `cfg_err` = 0, `busy` = 0, `cfg_ready` = 1, `periods` = 0.
  - Reset mid-operation aborts immediately; any pending divisor is discarded.
- Divider, active in RUN and DRAIN:
  - `cnt` runs 0 .. `div_cur`-1 and then wraps to 0.
  - Boundary is the cycle with `cnt` == `div_cur`-1.
  - `clk_div` (registered) is 1 when `cnt` ≥ `div_cur`/2, else 0. It is high for exactly `div_cur`/2 cycles per period.
  - `imp` = 1 for the single cycle in which `clk_div` goes 0→1.
- Handshake:
  - `cfg_ready` = !`pend`.
  - Transfer occurs when `cfg_valid` && `cfg_ready`.
  - `cfg_div` odd or < 2: the transfer is consumed, `cfg_err` pulses one cycle later, and `div_cur` and `pend` are unchanged.
  - Valid `cfg_div` in STOP: `div_cur` is loaded on the next edge and `pend` stays 0.
  - Valid `cfg_div` in RUN or DRAIN: latched into `div_nxt` and `pend` is set.
  - Transfer on the boundary cycle itself: the new divisor is applied at that same wrap.
- Divisor update at a boundary with `pend` = 1:
  - `div_cur` ← `div_nxt`, `pend` ← 0, `cnt` ← 0.
- FSM transitions:
  - STOP → RUN: when `enable` = 1. `cnt` = 0 on the first RUN cycle.
  - RUN → DRAIN: when `enable` = 0 on a non-boundary cycle.
  - RUN → STOP: when `enable` = 0 on a boundary cycle.
  - DRAIN → RUN: when `enable` returns to 1 before the boundary. The count continues and no restart occurs.
  - DRAIN → STOP: at the boundary. `cnt` ← 0 and `clk_div` ends at 0.
  - STOP holds `cnt` = 0 and `clk_div` = 0.
- `busy` = (`state` != STOP).

Optional Feature:
- DIV_SEQ_PERIODS_EN defined:
  - `periods` increments at every boundary in RUN or DRAIN and wraps 0xFFFF→0.
  - Cleared to 0 on reset and on every `div_cur` load, including loads made in STOP.
- Not defined:
  - `periods` is tied to 0 and no counter logic is built.
  - The port list is identical in both builds.

Test Plan:
- Reset, then `enable` = 1 with DEF_DIV = 6:
  - `clk_div` pattern is 000111 repeating.
  - `imp` pulses every 6 cycles, aligned with each `clk_div` rise.
  - `busy` = 1.
- While RUN at `cnt` = 2, offer `cfg_div` = 4:
  - `cfg_ready` drops the next cycle.
  - The div-6 period completes, then the pattern becomes 0011.
  - `cfg_ready` returns to 1 after the load.
- Offer `cfg_div` = 5, then `cfg_div` = 0:
  - Two `cfg_err` pulses.
  - `div_cur` stays 6 and the waveform is unchanged.
- Drop `enable` at `cnt` = 3:
  - DRAIN completes through `cnt` = 5, then STOP.
  - `clk_div` = 0 and `busy` = 0 on the following cycle.
  - No truncated high phase.
- Drop `enable` at `cnt` = 1 and re-raise it at `cnt` = 3:
  - Period continues uninterrupted with no restart.
- Assert `reset` with `pend` = 1 mid-period:
  - All outputs go to reset values and `div_cur` = 6.
  - With DIV_SEQ_PERIODS_EN, `periods` = 0, and it counts 1 after the first full period once restarted.
